// File: rtl/wishbone_master_if.sv
// Command/response streams and Wishbone initiator bus for wishbone_master.
// The master modport is the initiator's view; the slave modport is the
// environment's view (command source, response sink and Wishbone target).
interface wishbone_master_if;
  // Command stream
  logic        cmd_val;
  logic        cmd_rdy;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  // Response stream
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_dat;
  logic        resp_err;
  // Wishbone classic initiator signals
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_val, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_rdy,
    output resp_val, resp_dat, resp_err,
    input  resp_rdy,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_val, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_rdy,
    input  resp_val, resp_dat, resp_err,
    output resp_rdy,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wishbone_master.sv
// Wishbone classic-cycle initiator: one command in, one bus cycle out, one
// response back. A single transaction is outstanding at a time, and the ack
// wait is bounded by TIMEOUT cycles (0 = wait forever).
module wishbone_master #(
  parameter int unsigned TIMEOUT = 255
) (
`ifdef USE_POWER_PINS
  inout wire vccd1,
  inout wire vssd1,
`endif
  input logic           clk,
  input logic           reset,
  wishbone_master_if.master bus
);

  // With TIMEOUT = 0 the counter is unused for termination but still saturates.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          we_q,    we_d;
  logic [3:0]    sel_q,   sel_d;
  logic [31:0]   adr_q,   adr_d;
  logic [31:0]   dat_q,   dat_d;
  logic [31:0]   rdat_q,  rdat_d;
  logic          err_q,   err_d;

  // State, counter, bus-request and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, hold in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_val) begin
          state_d = S_REQ;
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // Ack is checked first so a coincident timeout still returns the data.
        if (bus.wbm_ack_i) begin
          state_d = S_RESP;
          rdat_d  = we_q ? '0 : bus.wbm_dat_i;
          err_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          rdat_d  = '0;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.resp_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_rdy   = reset && (state_q == S_IDLE);
  assign bus.wbm_cyc_o = (state_q == S_REQ);
  assign bus.wbm_stb_o = (state_q == S_REQ);
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.resp_val  = (state_q == S_RESP);
  assign bus.resp_dat  = rdat_q;
  assign bus.resp_err  = err_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: three instances (TIMEOUT 255, 4, 3) share clock
// and reset. A transaction-level model predicts bus-cycle length, error flag
// and read data from a small slave memory.
module tb_wishbone_master;

  localparam int unsigned NDUT = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic        cmd_val  [NDUT];
  logic        cmd_we   [NDUT];
  logic [31:0] cmd_adr  [NDUT];
  logic [31:0] cmd_dat  [NDUT];
  logic [3:0]  cmd_sel  [NDUT];
  logic        resp_rdy [NDUT];
  logic        ack      [NDUT];
  logic [31:0] dat_i    [NDUT];

  logic        cmd_rdy  [NDUT];
  logic        resp_val [NDUT];
  logic        resp_err [NDUT];
  logic [31:0] resp_dat [NDUT];
  logic        cyc      [NDUT];
  logic        stb      [NDUT];
  logic        we_o     [NDUT];
  logic [3:0]  sel_o    [NDUT];
  logic [31:0] adr_o    [NDUT];
  logic [31:0] dat_o    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned TOG = (g == 0) ? 255 : (g == 1) ? 4 : 3;
    wishbone_master_if bus ();
    assign bus.cmd_val   = cmd_val[g];
    assign bus.cmd_we    = cmd_we[g];
    assign bus.cmd_adr   = cmd_adr[g];
    assign bus.cmd_dat   = cmd_dat[g];
    assign bus.cmd_sel   = cmd_sel[g];
    assign bus.resp_rdy  = resp_rdy[g];
    assign bus.wbm_ack_i = ack[g];
    assign bus.wbm_dat_i = dat_i[g];
    assign cmd_rdy[g]    = bus.cmd_rdy;
    assign resp_val[g]   = bus.resp_val;
    assign resp_err[g]   = bus.resp_err;
    assign resp_dat[g]   = bus.resp_dat;
    assign cyc[g]        = bus.wbm_cyc_o;
    assign stb[g]        = bus.wbm_stb_o;
    assign we_o[g]       = bus.wbm_we_o;
    assign sel_o[g]      = bus.wbm_sel_o;
    assign adr_o[g]      = bus.wbm_adr_o;
    assign dat_o[g]      = bus.wbm_dat_o;
    wishbone_master #(.TIMEOUT(TOG)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.master)
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave memory: eight words at 0x3000_0000..0x3000_001C.
  logic [31:0] mem [8];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned to_of(input int d);
    case (d)
      0:       return 255;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  // Slave behaviour for bus cycle t (1-based from command acceptance).
  task automatic drive_ack(input int d, input int t, input int ack_at, input int hold,
                           input logic [31:0] adr);
    ack[d]   = (ack_at != 0) && (t >= ack_at) && (t < ack_at + hold);
    dat_i[d] = ack[d] ? mem[adr[4:2]] : $urandom;
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_ctl"},
          80'({cmd_rdy[d], resp_val[d], resp_err[d], cyc[d], stb[d], we_o[d], sel_o[d], adr_o[d]}),
          80'(0));
    check({tag, "_dat"}, 80'({dat_o[d], resp_dat[d]}), 80'(0));
  endtask

  // One full transaction: issue, watch the bus cycle, hold the response
  // for rwait cycles, release, then watch a few idle cycles.
  task automatic txn(input int d, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input int ack_at, input int ack_hold, input int rwait);
    int unsigned to;
    bit          tmo;
    int          exp_cycles;
    logic [31:0] exp_dat;
    logic [31:0] m;
    int          n;
    int          t;
    bit          done;
    to         = to_of(d);
    tmo        = (to != 0) && ((ack_at == 0) || (ack_at > int'(to)));
    exp_cycles = tmo ? int'(to) : ack_at;
    exp_dat    = (tmo || we) ? 32'h0 : mem[adr[4:2]];

    @(negedge clk);
    check("cmd_rdy_idle", 80'(cmd_rdy[d]), 80'(1'b1));
    cmd_val[d]  = 1'b1;
    cmd_we[d]   = we;
    cmd_adr[d]  = adr;
    cmd_dat[d]  = dat;
    cmd_sel[d]  = sel;
    resp_rdy[d] = 1'b0;
    @(posedge clk); #1;
    cmd_val[d] = 1'b0;
    cmd_we[d]  = ~we;
    cmd_adr[d] = $urandom;
    cmd_dat[d] = $urandom;
    cmd_sel[d] = 4'($urandom);

    n = 0; t = 0; done = 1'b0;
    while (!done && t < 400) begin
      t++;
      drive_ack(d, t, ack_at, ack_hold, adr);
      @(negedge clk);
      if (cyc[d]) begin
        n++;
        check("req_bus",
              80'({cyc[d], stb[d], we_o[d], sel_o[d], adr_o[d], dat_o[d], cmd_rdy[d], resp_val[d]}),
              80'({2'b11, we, sel, adr, dat, 2'b00}));
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    check("req_done", 80'(done), 80'(1'b1));
    check("req_cycles", 80'(n), 80'(exp_cycles));

    if (we && !tmo) begin
      m = mem[adr[4:2]];
      for (int i = 0; i < 4; i++)
        if (sel[i]) m[8*i +: 8] = dat[8*i +: 8];
      mem[adr[4:2]] = m;
    end

    for (int r = 0; r <= rwait; r++) begin
      check("resp",
            80'({resp_val[d], resp_err[d], resp_dat[d], cyc[d], stb[d], cmd_rdy[d]}),
            80'({1'b1, tmo, exp_dat, 3'b000}));
      if (r == rwait) resp_rdy[d] = 1'b1;
      @(posedge clk); #1;
      resp_rdy[d] = 1'b0;
      t++;
      drive_ack(d, t, ack_at, ack_hold, adr);
      @(negedge clk);
    end

    for (int k = 0; k < 3; k++) begin
      check("idle_after", 80'({resp_val[d], cyc[d], stb[d], cmd_rdy[d]}), 80'(4'b0001));
      @(posedge clk); #1;
      t++;
      drive_ack(d, t, ack_at, ack_hold, adr);
      @(negedge clk);
    end
    ack[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      cmd_val[d]  = 1'b0;
      cmd_we[d]   = 1'b0;
      cmd_adr[d]  = '0;
      cmd_dat[d]  = '0;
      cmd_sel[d]  = '0;
      resp_rdy[d] = 1'b0;
      ack[d]      = 1'b0;
      dat_i[d]    = '0;
    end
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset values, immediately and after edges under reset.
    #1;
    for (int d = 0; d < NDUT; d++) check_reset_outputs(d, "rst_now");
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_reset_outputs(d, "rst_held");
    #2 rst_n = 1'b1;

    // Loopback write then read back.
    txn(0, 1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 1, 1, 0);
    txn(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 1, 0);
    // Delayed ack after 7 cycles.
    txn(0, 1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 7, 1, 0);
    // Timeout (TIMEOUT=4) with a late ack arriving after the drop.
    txn(1, 1'b1, 32'h3000_0008, 32'h1111_2222, 4'hF, 6, 3, 0);
    // Response backpressure for 10 cycles.
    txn(0, 1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 1, 10);
    // Ack coinciding with timeout (TIMEOUT=3), read.
    mem[3] = 32'h1234_5678;
    txn(2, 1'b0, 32'h3000_000C, 32'h0, 4'hF, 3, 1, 0);
    // Ack one cycle past timeout on the same instance: timeout wins.
    txn(2, 1'b0, 32'h3000_000C, 32'h0, 4'hF, 4, 1, 0);
    // Slave holds ack for many cycles; byte-select partial write.
    txn(0, 1'b1, 32'h3000_0000, 32'h5566_7788, 4'b0101, 2, 6, 1);
    txn(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 1, 0);

    // Asynchronous reset in the middle of REQ.
    @(negedge clk);
    cmd_val[0] = 1'b1; cmd_we[0] = 1'b0; cmd_adr[0] = 32'h3000_0010;
    cmd_sel[0] = 4'hF; resp_rdy[0] = 1'b0;
    @(posedge clk); #1;
    cmd_val[0] = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_cyc", 80'({cyc[0], stb[0]}), 80'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "rst_mid");
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_idle", 80'({resp_val[0], cyc[0], stb[0], cmd_rdy[0]}), 80'(4'b0001));
    end

    // Randomized transactions across all three instances.
    for (int i = 0; i < 40; i++) begin
      int          d;
      logic        we;
      logic [31:0] adr;
      d   = int'($urandom_range(0, 2));
      we  = 1'($urandom);
      adr = 32'h3000_0000 + 32'(4 * $urandom_range(0, 7));
      txn(d, we, adr, $urandom, 4'($urandom_range(1, 15)),
          int'($urandom_range(0, 9)), int'($urandom_range(1, 4)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
